// File: rtl/arm_pkg.sv
// Shared widths, types and timing-constant helpers for the arm servo PWM driver.
package arm_pkg;

  localparam int AXIS_W = 10;
  localparam int unsigned POS_MAX = (1 << AXIS_W) - 1;
  localparam int unsigned DEFAULT_CLK_FREQ = 50_000_000;

  typedef logic [AXIS_W-1:0] coord_t;

  function automatic int unsigned frameClks(input int unsigned clkFreq, input int unsigned pwmFreq);
    return clkFreq / pwmFreq;
  endfunction

  function automatic int unsigned pulseClks(input int unsigned clkFreq, input int unsigned pulseUs);
    return (clkFreq / 1_000_000) * pulseUs;
  endfunction

  // Clocks per position step; the top checks maxClks >= minClks before using it.
  function automatic int unsigned stepClks(input int unsigned minClks, input int unsigned maxClks);
    return (maxClks - minClks) / POS_MAX;
  endfunction

endpackage

// File: rtl/arm_axis_slew.sv
// One servo axis: slew-limited position register, pulse threshold and registered PWM compare.
module arm_axis_slew
  import arm_pkg::*;
#(
  parameter int unsigned MAX_STEP  = 8,
  parameter int unsigned HOME_POS  = 512,
  parameter int unsigned MIN_CLKS  = 50_000,
  parameter int unsigned STEP_CLKS = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wrap,
  input  logic        i_enable,
  input  logic [31:0] i_frameCnt,
  input  coord_t      i_target,
  output logic        o_pwm,
  output logic        o_atTarget
);

  localparam coord_t             HOME_C = HOME_POS[AXIS_W-1:0];
  localparam logic [AXIS_W:0]    STEP_C = MAX_STEP[AXIS_W:0];

  coord_t                r_pos;
  logic                  r_pwm;
  logic                  r_atTarget;
  logic signed [AXIS_W:0] w_diff;
  logic [AXIS_W:0]       w_absDiff;
  coord_t                w_nextPos;
  logic [31:0]           w_thresh;

  // Both operands are 0..1023, so an 11-bit signed difference cannot overflow.
  always_comb begin
    w_diff    = $signed({1'b0, i_target}) - $signed({1'b0, r_pos});
    w_absDiff = w_diff[AXIS_W] ? $unsigned(-w_diff) : $unsigned(w_diff);
    w_nextPos = i_target;
    if (w_absDiff > STEP_C) begin
      if (w_diff[AXIS_W]) begin
        w_nextPos = r_pos - STEP_C[AXIS_W-1:0];
      end else begin
        w_nextPos = r_pos + STEP_C[AXIS_W-1:0];
      end
    end
  end

  assign w_thresh = MIN_CLKS + {{(32-AXIS_W){1'b0}}, r_pos} * STEP_CLKS;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos      <= HOME_C;
      r_atTarget <= 1'b0;
      r_pwm      <= 1'b0;
    end else begin
      if (i_wrap) begin
        r_pos      <= w_nextPos;
        r_atTarget <= (w_nextPos == i_target);
      end
      r_pwm <= i_enable & (i_frameCnt < w_thresh);
    end
  end

  assign o_pwm      = r_pwm;
  assign o_atTarget = r_atTarget;

endmodule

// File: rtl/arm_servo_pwm_driver.sv
// Three-axis hobby-servo driver: shared frame timing, per-axis slew and PWM, in-position status.
module arm_servo_pwm_driver
  import arm_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = DEFAULT_CLK_FREQ,
  parameter int unsigned PWM_FREQ     = 50,
  parameter int unsigned MIN_PULSE_US = 1000,
  parameter int unsigned MAX_PULSE_US = 2000,
  parameter int unsigned MAX_STEP     = 8,
  parameter int unsigned HOME_POS     = 512
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   enable,
  input  coord_t x_in,
  input  coord_t y_in,
  input  coord_t z_in,
  output logic   pwm_x,
  output logic   pwm_y,
  output logic   pwm_z,
  output logic   frame_tick,
  output logic   in_position
);

  localparam int unsigned FRAME_CLKS = frameClks(CLK_FREQ, PWM_FREQ);
  localparam int unsigned MIN_CLKS   = pulseClks(CLK_FREQ, MIN_PULSE_US);
  localparam int unsigned MAX_CLKS   = pulseClks(CLK_FREQ, MAX_PULSE_US);
  localparam int unsigned STEP_CLKS  = stepClks(MIN_CLKS, MAX_CLKS);

  if ((MAX_CLKS < MIN_CLKS) || (MIN_CLKS + POS_MAX * STEP_CLKS >= FRAME_CLKS) ||
      (MAX_STEP < 1) || (MAX_STEP > POS_MAX) || (HOME_POS > POS_MAX)) begin : g_badParams
    $error("arm_servo_pwm_driver: longest pulse does not fit in a frame, or MAX_STEP/HOME_POS out of range");
  end

  logic [31:0] r_frameCnt;
  logic        r_frameTick;
  logic        w_wrap;
  coord_t      w_target [3];
  logic [2:0]  w_pwm;
  logic [2:0]  w_atTarget;

  assign w_wrap = (r_frameCnt == FRAME_CLKS - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frameCnt  <= '0;
      r_frameTick <= 1'b0;
    end else begin
      r_frameCnt  <= w_wrap ? '0 : r_frameCnt + 32'd1;
      r_frameTick <= w_wrap;
    end
  end

  assign w_target[0] = x_in;
  assign w_target[1] = y_in;
  assign w_target[2] = z_in;

  for (genvar a = 0; a < 3; a++) begin : g_axis
    arm_axis_slew #(
      .MAX_STEP  (MAX_STEP),
      .HOME_POS  (HOME_POS),
      .MIN_CLKS  (MIN_CLKS),
      .STEP_CLKS (STEP_CLKS)
    ) u_axis (
      .clk        (clk),
      .rst        (rst),
      .i_wrap     (w_wrap),
      .i_enable   (enable),
      .i_frameCnt (r_frameCnt),
      .i_target   (w_target[a]),
      .o_pwm      (w_pwm[a]),
      .o_atTarget (w_atTarget[a])
    );
  end

  assign pwm_x       = w_pwm[0];
  assign pwm_y       = w_pwm[1];
  assign pwm_z       = w_pwm[2];
  assign frame_tick  = r_frameTick;
  assign in_position = &w_atTarget;

endmodule
